// File: rtl/hook_controller.sv
// hook_controller: owns the hook swing angle and rope length, steps them once per
// accepted frame tick and hands each new pose to the hook-draw FSM.
module hook_controller #(
  parameter int MIN_DEG  = 20,
  parameter int MAX_DEG  = 160,
  parameter int DEG_STEP = 2,
  parameter int MIN_LEN  = 16,
  parameter int MAX_LEN  = 200,
  parameter int EXT_STEP = 4,
  parameter int RET_STEP = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic       hit,
  input  logic [1:0] weight,
  input  logic       draw_done,
  output logic [8:0] degree,
  output logic [9:0] length,
  output logic       draw_enable,
  output logic       busy,
  output logic       grab_done,
  output logic       caught
);

  typedef enum logic [1:0] {SWING, EXTEND, RETRACT} motion_t;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_WAIT} draw_t;

  motion_t    motion, motion_next;
  draw_t      draw_state, draw_next;
  logic       dir, dir_next;
  logic       fire_flag, fire_flag_next;
  logic       hit_flag, hit_flag_next;
  logic [1:0] hit_weight, hit_weight_next;
  logic [1:0] grab_weight, grab_weight_next;
  logic       caught_r, caught_r_next;
  logic       caught_next, grab_done_next;
  logic [8:0] degree_next;
  logic [9:0] length_next;
  logic       accept, fire_now, hit_now;
  logic [1:0] weight_now;
  logic [9:0] shifted_step, ret_step;
  logic [9:0] deg_sum;
  logic [10:0] len_sum;

  assign draw_enable = (draw_state == D_REQ);
  assign busy        = (draw_state != D_IDLE);

  always_comb begin
    draw_next = draw_state;
    case (draw_state)
      D_IDLE:  if (accept) draw_next = D_REQ;
      D_REQ:   draw_next = D_WAIT;
      D_WAIT:  if (draw_done) draw_next = D_IDLE;
      default: draw_next = D_IDLE;
    endcase
  end

  // Same-cycle fire/hit count as if already latched; the first latched weight wins.
  always_comb begin
    accept       = frame_tick && (draw_state == D_IDLE);
    fire_now     = fire_flag || fire;
    hit_now      = hit_flag || hit;
    weight_now   = hit_flag ? hit_weight : weight;
    deg_sum      = {1'b0, degree} + 10'(DEG_STEP);
    len_sum      = {1'b0, length} + 11'(EXT_STEP);
    shifted_step = 10'(RET_STEP) >> grab_weight;
    if (!caught_r)                ret_step = 10'(RET_STEP);
    else if (shifted_step == '0)  ret_step = 10'd1;
    else                          ret_step = shifted_step;

    motion_next      = motion;
    dir_next         = dir;
    degree_next      = degree;
    length_next      = length;
    caught_r_next    = caught_r;
    grab_weight_next = grab_weight;
    caught_next      = caught;
    grab_done_next   = 1'b0;
    fire_flag_next   = fire_flag;
    hit_flag_next    = hit_flag;
    hit_weight_next  = hit_weight;

    if (accept) begin
      fire_flag_next = 1'b0;
      hit_flag_next  = 1'b0;
      case (motion)
        SWING: begin
          if (fire_now) begin
            motion_next = EXTEND;
          end else if (dir) begin
            if (deg_sum >= 10'(MAX_DEG)) begin
              degree_next = 9'(MAX_DEG);
              dir_next    = 1'b0;
            end else begin
              degree_next = deg_sum[8:0];
            end
          end else begin
            if (degree <= 9'(MIN_DEG + DEG_STEP)) begin
              degree_next = 9'(MIN_DEG);
              dir_next    = 1'b1;
            end else begin
              degree_next = degree - 9'(DEG_STEP);
            end
          end
        end
        EXTEND: begin
          if (hit_now) begin
            caught_r_next    = 1'b1;
            grab_weight_next = weight_now;
            motion_next      = RETRACT;
          end else if (len_sum >= 11'(MAX_LEN)) begin
            length_next   = 10'(MAX_LEN);
            caught_r_next = 1'b0;
            motion_next   = RETRACT;
          end else begin
            length_next = len_sum[9:0];
          end
        end
        RETRACT: begin
          // Compare before subtracting so a large step never wraps below zero.
          if (length <= 10'(MIN_LEN) + ret_step) begin
            length_next    = 10'(MIN_LEN);
            motion_next    = SWING;
            grab_done_next = 1'b1;
            caught_next    = caught_r;
          end else begin
            length_next = length - ret_step;
          end
        end
        default: motion_next = SWING;
      endcase
    end else begin
      if (motion == SWING && fire) fire_flag_next = 1'b1;
      if (motion == EXTEND && hit && !hit_flag) begin
        hit_flag_next   = 1'b1;
        hit_weight_next = weight;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      motion      <= SWING;
      draw_state  <= D_IDLE;
      dir         <= 1'b1;
      degree      <= 9'd90;
      length      <= 10'(MIN_LEN);
      fire_flag   <= 1'b0;
      hit_flag    <= 1'b0;
      hit_weight  <= 2'd0;
      grab_weight <= 2'd0;
      caught_r    <= 1'b0;
      caught      <= 1'b0;
      grab_done   <= 1'b0;
    end else begin
      motion      <= motion_next;
      draw_state  <= draw_next;
      dir         <= dir_next;
      degree      <= degree_next;
      length      <= length_next;
      fire_flag   <= fire_flag_next;
      hit_flag    <= hit_flag_next;
      hit_weight  <= hit_weight_next;
      grab_weight <= grab_weight_next;
      caught_r    <= caught_r_next;
      caught      <= caught_next;
      grab_done   <= grab_done_next;
    end
  end

endmodule

// File: tb/tb_hook_controller.sv
// tb_hook_controller: directed scenarios plus random traffic, checked by a
// scoreboard fed from a behavioural hook model.
module tb_hook_controller;

  localparam int MIN_DEG = 20, MAX_DEG = 160, DEG_STEP = 2;
  localparam int MIN_LEN = 16, MAX_LEN = 200, EXT_STEP = 4, RET_STEP = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0, fire = 1'b0, hit = 1'b0, draw_done = 1'b0;
  logic [1:0] weight = 2'd0;
  logic [8:0] degree;
  logic [9:0] length;
  logic       draw_enable, busy, grab_done, caught;

  hook_controller dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .fire(fire),
    .hit(hit), .weight(weight), .draw_done(draw_done), .degree(degree),
    .length(length), .draw_enable(draw_enable), .busy(busy),
    .grab_done(grab_done), .caught(caught)
  );

  always #5 clock = ~clock;

  typedef struct {int deg; int len; int grab; int caught;} pose_t;
  pose_t exp_q[$];

  int checks = 0, errors = 0, grab_seen = 0;
  // Model: mode 0 = swinging, 1 = extending, 2 = retracting.
  int m_mode, m_deg, m_len, m_dir, m_fire, m_hit, m_hw, m_caught_r, m_gw, m_caught;
  int edge_k = 0, last_accept = -100, done_edge = -100, free_edge = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_deg = 90; m_len = MIN_LEN; m_dir = 1;
    m_fire = 0; m_hit = 0; m_hw = 0; m_caught_r = 0; m_gw = 0; m_caught = 0;
    last_accept = -100; done_edge = -100; free_edge = 0;
  endfunction

  function automatic void model_edge(input bit t, input bit f, input bit h, input int w, input int d);
    int grab, st, nd, nl;
    grab = 0;
    if (t && edge_k >= free_edge) begin
      if (m_mode == 0) begin
        if (m_fire != 0 || f) m_mode = 1;
        else if (m_dir == 1) begin
          m_deg = m_deg + DEG_STEP;
          if (m_deg >= MAX_DEG) begin m_deg = MAX_DEG; m_dir = 0; end
        end else begin
          nd = m_deg - DEG_STEP;
          if (nd <= MIN_DEG) begin m_deg = MIN_DEG; m_dir = 1; end
          else m_deg = nd;
        end
      end else if (m_mode == 1) begin
        if (m_hit != 0 || h) begin
          m_caught_r = 1; m_gw = (m_hit != 0) ? m_hw : w; m_mode = 2;
        end else begin
          m_len = m_len + EXT_STEP;
          if (m_len >= MAX_LEN) begin m_len = MAX_LEN; m_caught_r = 0; m_mode = 2; end
        end
      end else begin
        st = (m_caught_r != 0) ? (RET_STEP >> m_gw) : RET_STEP;
        if (st < 1) st = 1;
        nl = m_len - st;
        if (nl <= MIN_LEN) begin
          m_len = MIN_LEN; m_mode = 0; grab = 1; m_caught = m_caught_r;
        end else m_len = nl;
      end
      m_fire = 0; m_hit = 0;
      exp_q.push_back('{m_deg, m_len, grab, m_caught});
      last_accept = edge_k;
      done_edge = edge_k + 1 + d;
      free_edge = done_edge + 1;
    end else begin
      if (m_mode == 0 && f) m_fire = 1;
      if (m_mode == 1 && h && m_hit == 0) begin m_hit = 1; m_hw = w; end
    end
  endfunction

  // One clock edge of stimulus; d is the draw latency used if this tick is accepted.
  task automatic applyStimulus(input bit t, input bit f, input bit h, input int w,
                               input int d, input bit spur);
    bit allowed;
    allowed = (edge_k >= free_edge) || (edge_k == last_accept + 1);
    resetn = 1'b1; frame_tick = t; fire = f; hit = h; weight = 2'(w);
    draw_done = (edge_k == done_edge) || (spur && allowed);
    model_edge(t, f, h, w, d);
    @(posedge clock); #1;
    checkOutput("busy", int'(busy), int'(edge_k >= last_accept && edge_k < done_edge));
    edge_k++;
  endtask

  task automatic applyReset();
    resetn = 1'b0; frame_tick = 1'b1; fire = 1'b1; hit = 1'b1; draw_done = 1'b1; weight = 2'd3;
    model_reset();
    exp_q.delete();
    @(posedge clock); #1;
    edge_k++;
  endtask

  task automatic tickAndWait(input bit f, input bit h, input int w);
    applyStimulus(1'b1, f, h, w, 3, 1'b0);
    while (edge_k < free_edge) applyStimulus(1'b0, 1'b0, 1'b0, 0, 3, 1'b0);
  endtask

  // Monitor: every draw_enable must match the next pose the model predicted.
  always @(negedge clock) begin
    if (resetn) begin
      if (draw_enable) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_draw_enable actual=1 expected=0 at %0t", $time);
        end else begin
          pose_t e;
          e = exp_q.pop_front();
          checkOutput("pose_degree", int'(degree), e.deg);
          checkOutput("pose_length", int'(length), e.len);
          checkOutput("pose_grab_done", int'(grab_done), e.grab);
          checkOutput("pose_caught", int'(caught), e.caught);
          if (grab_done) grab_seen++;
        end
      end else begin
        checkOutput("stray_grab_done", int'(grab_done), 0);
      end
    end
  end

  initial begin
    model_reset();
    applyReset(); applyReset();
    checkOutput("reset_degree", int'(degree), 90);
    checkOutput("reset_length", int'(length), 16);
    checkOutput("reset_draw_enable", int'(draw_enable), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_grab_done", int'(grab_done), 0);
    checkOutput("reset_caught", int'(caught), 0);

    // Swing bounce off MAX_DEG.
    for (int i = 0; i < 35; i++) tickAndWait(1'b0, 1'b0, 0);
    checkOutput("swing_max", int'(degree), 160);
    tickAndWait(1'b0, 1'b0, 0);
    checkOutput("swing_back", int'(degree), 158);

    // Ticks dropped while the draw FSM holds off draw_done.
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 12, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus((i % 3) == 2, 1'b0, 1'b0, 0, 3, 1'b0);
    while (edge_k < free_edge) applyStimulus(1'b0, 1'b0, 1'b0, 0, 3, 1'b0);
    checkOutput("dropped_hold", int'(degree), 156);
    tickAndWait(1'b0, 1'b0, 0);
    checkOutput("dropped_resume", int'(degree), 154);

    // Tick coinciding with draw_done is dropped.
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 3, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 3, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 3, 1'b0);
    checkOutput("done_tick_drop", int'(degree), 152);
    tickAndWait(1'b0, 1'b0, 0);
    checkOutput("after_done_tick", int'(degree), 150);

    // Launch with no hit from degree 90; fire shares the cycle with the tick.
    applyReset();
    grab_seen = 0;
    tickAndWait(1'b1, 1'b0, 0);
    checkOutput("fire_same_tick_len", int'(length), 16);
    for (int i = 0; i < 46; i++) tickAndWait(1'b0, 1'b0, 0);
    checkOutput("full_length", int'(length), 200);
    for (int i = 0; i < 46; i++) tickAndWait(1'b0, 1'b0, 0);
    checkOutput("empty_grab_count", grab_seen, 1);
    checkOutput("empty_caught", int'(caught), 0);
    checkOutput("empty_degree", int'(degree), 90);

    // Latched fire, then a hit of weight 2 (a later weight-0 hit must be ignored).
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 3, 1'b0);
    tickAndWait(1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) tickAndWait(1'b0, 1'b0, 0);
    checkOutput("hit_start_len", int'(length), 40);
    applyStimulus(1'b0, 1'b0, 1'b1, 2, 3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 3, 1'b0);
    tickAndWait(1'b0, 1'b0, 0);
    checkOutput("hit_tick_len", int'(length), 40);
    for (int i = 0; i < 23; i++) tickAndWait(1'b0, 1'b0, 0);
    checkOutput("slow_retract_len", int'(length), 17);
    checkOutput("caught_holds", int'(caught), 0);
    tickAndWait(1'b0, 1'b0, 0);
    checkOutput("hit_grab_count", grab_seen, 2);
    checkOutput("hit_caught", int'(caught), 1);

    // Reset while retracting at length 100 with a draw outstanding.
    tickAndWait(1'b1, 1'b0, 0);
    for (int i = 0; i < 21; i++) tickAndWait(1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 0, 3, 1'b0);
    checkOutput("pre_reset_len", int'(length), 100);
    applyReset();
    checkOutput("midreset_degree", int'(degree), 90);
    checkOutput("midreset_length", int'(length), 16);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_grab_done", int'(grab_done), 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 3, 1'b0);
    checkOutput("midreset_no_grab", grab_seen, 2);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) applyReset();
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 19) == 0, int'($urandom_range(0, 3)),
                    int'($urandom_range(1, 5)), $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 3, 1'b0);
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
